cut_pattern_sequencer: RTL and testbench

- Sequential test-harness stage for power/function characterization of 3-input combinational library cells (AO21X1 class).
- Sits directly upstream and downstream of the cell-under-test (CUT): drives its inputs with exhaustive binary or Gray sweeps and samples its output Q.
- Accumulates rise, fall and ones counts plus a MISR signature on Q.
- Controlled by a START/BUSY/DONE handshake.

---
 rtl/cut_seq_pkg.sv | 22 ++
 rtl/cut_pattern_sequencer_if.sv | 37 +++
 rtl/cut_misr.sv | 34 +++
 rtl/cut_pattern_sequencer.sv | 153 +++++++++++++++
 tb/tb_cut_pattern_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cut_seq_pkg.sv
// Shared types and constants for the cell-under-test pattern sequencer:
// FSM states, MISR polynomial/seed and the binary-to-Gray helper.
package cut_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MISR_W = 16;

    // x^16 + x^12 + x^3 + x + 1; the x^16 term is implied by the shift-out.
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h100B;
    localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/cut_pattern_sequencer_if.sv
// Bundle of the control handshake, CUT stimulus/response and result
// signals between the sequencer and whoever drives and observes it.
interface cut_pattern_sequencer_if #(
    parameter int N_IN   = 3,
    parameter int REPS_W = 8,
    parameter int CNT_W  = 16,
    parameter int SIG_W  = 16
);

    // Handshake: START is a single-cycle request, accepted only on an edge
    // where BUSY is low (IDLE or DONE); REPS/MODE are captured on that edge.
    // BUSY stays high while the sweep runs, DONE is a level that holds with
    // stable results until the next accepted START or reset.
    logic                 START;
    logic [REPS_W-1:0]    REPS;
    logic                 MODE;
    logic [N_IN-1:0]      STIM;
    logic                 CUT_Q;
    logic                 BUSY;
    logic                 DONE;
    logic [CNT_W-1:0]     RISE_CNT;
    logic [CNT_W-1:0]     FALL_CNT;
    logic [CNT_W-1:0]     ONES_CNT;
    logic [SIG_W-1:0]     SIG;
    cut_seq_pkg::state_t  state;

    modport slave (
        input  START, REPS, MODE, CUT_Q,
        output STIM, BUSY, DONE, RISE_CNT, FALL_CNT, ONES_CNT, SIG, state
    );

    modport master (
        output START, REPS, MODE, CUT_Q,
        input  STIM, BUSY, DONE, RISE_CNT, FALL_CNT, ONES_CNT, SIG, state
    );

endinterface

// File: rtl/cut_misr.sv
// Single-input MISR (Galois form) with synchronous clear-to-seed and a
// shift enable; compresses the sampled CUT output stream.
module cut_misr
    import cut_seq_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(MISR_SEED)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clear,
    input  logic             shift,
    input  logic             d,
    output logic [SIG_W-1:0] sig
);

    logic feedback;

    always_comb begin
        feedback = sig[SIG_W-1] ^ d;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sig <= SEED;
        end else if (clear) begin
            sig <= SEED;
        end else if (shift) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ ({SIG_W{feedback}} & POLY);
        end
    end

endmodule

// File: rtl/cut_pattern_sequencer.sv
// Drives exhaustive binary/Gray sweeps into a combinational cell-under-test
// and accumulates rise/fall/ones counts plus a MISR signature of its output.
module cut_pattern_sequencer
    import cut_seq_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int REPS_W = 8,
    parameter int CNT_W  = 16,
    parameter int SIG_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RSTB,
    cut_pattern_sequencer_if.slave bus
);

    localparam logic [N_IN-1:0] IDX_LAST = '1;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic [N_IN-1:0]   idx_next;
    logic [REPS_W-1:0] reps_left;
    logic              mode_q;
    logic              prev_q;
    logic              have_prev;
    logic [N_IN-1:0]   stim_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  rise_q;
    logic [CNT_W-1:0]  fall_q;
    logic [CNT_W-1:0]  ones_q;
    logic [SIG_W-1:0]  sig;
    logic              start_ok;
    logic              last_sample;
    logic              misr_clear;
    logic              misr_shift;

    function automatic logic [N_IN-1:0] vector_of(input logic [N_IN-1:0] i,
                                                  input logic            gray);
        logic [31:0] g;
        g = bin2gray(32'(i));
        return gray ? g[N_IN-1:0] : i;
    endfunction

    always_comb begin
        start_ok    = bus.START && ((state == IDLE) || (state == DONE));
        idx_next    = idx + N_IN'(1);
        last_sample = (state == RUN) && (idx == IDX_LAST) && (reps_left == REPS_W'(1));
        misr_clear  = start_ok;
        misr_shift  = (state == RUN);
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state     <= IDLE;
            idx       <= '0;
            reps_left <= '0;
            mode_q    <= 1'b0;
            prev_q    <= 1'b0;
            have_prev <= 1'b0;
            stim_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rise_q    <= '0;
            fall_q    <= '0;
            ones_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        idx       <= '0;
                        reps_left <= bus.REPS;
                        mode_q    <= bus.MODE;
                        prev_q    <= 1'b0;
                        have_prev <= 1'b0;
                        rise_q    <= '0;
                        fall_q    <= '0;
                        ones_q    <= '0;
                        if (bus.REPS != '0) begin
                            state  <= LOAD;
                            stim_q <= vector_of('0, bus.MODE);
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end else begin
                            // Empty sweep: report zeroed results right away.
                            state  <= DONE;
                            stim_q <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    state <= RUN;
                end

                RUN: begin
                    if (bus.CUT_Q && (ones_q != '1)) begin
                        ones_q <= ones_q + CNT_W'(1);
                    end
                    // The first sample of a run only establishes the baseline.
                    if (have_prev && !prev_q && bus.CUT_Q && (rise_q != '1)) begin
                        rise_q <= rise_q + CNT_W'(1);
                    end
                    if (have_prev && prev_q && !bus.CUT_Q && (fall_q != '1)) begin
                        fall_q <= fall_q + CNT_W'(1);
                    end
                    prev_q    <= bus.CUT_Q;
                    have_prev <= 1'b1;
                    idx       <= idx_next;
                    if (idx == IDX_LAST) begin
                        reps_left <= reps_left - REPS_W'(1);
                    end
                    if (last_sample) begin
                        state  <= DONE;
                        stim_q <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        stim_q <= vector_of(idx_next, mode_q);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cut_misr #(
        .SIG_W (SIG_W),
        .POLY  (SIG_W'(MISR_POLY)),
        .SEED  (SIG_W'(MISR_SEED))
    ) u_misr (
        .clk   (CLK),
        .rstb  (RSTB),
        .clear (misr_clear),
        .shift (misr_shift),
        .d     (bus.CUT_Q),
        .sig   (sig)
    );

    assign bus.STIM     = stim_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.RISE_CNT = rise_q;
    assign bus.FALL_CNT = fall_q;
    assign bus.ONES_CNT = ones_q;
    assign bus.SIG      = sig;
    assign bus.state    = state;

endmodule

// File: tb/tb_cut_pattern_sequencer.sv
// Self-checking bench: drives sweeps into a truth-table CUT and compares the
// results against a sample-stream reference model.
module tb_cut_pattern_sequencer;
    import cut_seq_pkg::*;

    localparam int N_IN   = 3;
    localparam int REPS_W = 8;
    localparam int CNT_W  = 16;
    localparam int SIG_W  = 16;
    localparam int SAT_W  = 2;

    logic       CLK  = 1'b0;
    logic       RSTB = 1'b0;
    logic [7:0] cut_tt;

    always #5 CLK = ~CLK;

    cut_pattern_sequencer_if #(.N_IN(N_IN), .REPS_W(REPS_W), .CNT_W(CNT_W), .SIG_W(SIG_W)) bus ();
    cut_pattern_sequencer_if #(.N_IN(N_IN), .REPS_W(REPS_W), .CNT_W(SAT_W), .SIG_W(SIG_W)) sat_bus ();

    assign bus.CUT_Q     = cut_tt[bus.STIM];
    assign sat_bus.CUT_Q = 1'b1;

    cut_pattern_sequencer #(.N_IN(N_IN), .REPS_W(REPS_W), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus)
    );

    cut_pattern_sequencer #(.N_IN(N_IN), .REPS_W(REPS_W), .CNT_W(SAT_W), .SIG_W(SIG_W)) dut_sat (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (sat_bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hDEAD_BEEF;
        return exp_q.pop_front();
    endfunction

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic d);
        logic        fb;
        logic [15:0] r;
        fb = s[15] ^ d;
        r  = s << 1;
        if (fb) begin
            r[12] = ~r[12];
            r[3]  = ~r[3];
            r[1]  = ~r[1];
            r[0]  = ~r[0];
        end
        return r;
    endfunction

    function automatic int vec_of(input int i, input logic mode);
        return mode ? (i ^ (i >> 1)) : i;
    endfunction

    // Expected STIM after the m-th edge counted from the edge before START.
    function automatic int stim_at(input int m, input int reps, input logic mode);
        int i;
        if (reps == 0 || m >= reps * 8 + 2) return 0;
        i = (m <= 2) ? 0 : (m - 2) % 8;
        return vec_of(i, mode);
    endfunction

    // Pushes expected rise, fall, ones, sig for one complete run.
    task automatic model_push(input logic [7:0] tt, input logic mode, input int reps,
                              input int cnt_max);
        bit          samples[$];
        int          rise = 0;
        int          fall = 0;
        int          ones = 0;
        logic [15:0] sig  = 16'hFFFF;
        for (int k = 0; k < reps * 8; k++) begin
            samples.push_back(tt[vec_of(k % 8, mode)]);
        end
        foreach (samples[k]) begin
            if (samples[k]) ones++;
            if (k > 0 && !samples[k-1] && samples[k]) rise++;
            if (k > 0 && samples[k-1] && !samples[k]) fall++;
            sig = misr_ref(sig, samples[k]);
        end
        exp_q.push_back(32'((rise < cnt_max) ? rise : cnt_max));
        exp_q.push_back(32'((fall < cnt_max) ? fall : cnt_max));
        exp_q.push_back(32'((ones < cnt_max) ? ones : cnt_max));
        exp_q.push_back(32'(sig));
    endtask

    task automatic run_seq(input logic [7:0] tt, input logic mode, input int reps, input string tag);
        int          edges    = 0;
        int          busy_bad = 0;
        int          stim_bad = 0;
        int          lat;
        logic [31:0] exp_sig;
        lat = (reps == 0) ? 1 : reps * 8 + 2;
        model_push(tt, mode, reps, (1 << CNT_W) - 1);
        cut_tt = tt;
        @(posedge CLK); #1;
        bus.START = 1'b1;
        bus.REPS  = REPS_W'(reps);
        bus.MODE  = mode;
        forever begin
            @(posedge CLK); #1;
            edges++;
            if (int'(bus.STIM) != stim_at(edges, reps, mode)) stim_bad++;
            if (bus.DONE || edges >= lat + 8) break;
            if (!bus.BUSY) busy_bad++;
            bus.START = 1'($urandom_range(0, 1));
            bus.REPS  = REPS_W'($urandom);
            bus.MODE  = 1'($urandom);
        end
        bus.START = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        check({tag, "_done"}, 32'(bus.DONE), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_busy_trace"}, 32'(busy_bad), 32'd0);
        check({tag, "_stim_trace"}, 32'(stim_bad), 32'd0);
        check({tag, "_rise"}, 32'(bus.RISE_CNT), pop_exp());
        check({tag, "_fall"}, 32'(bus.FALL_CNT), pop_exp());
        check({tag, "_ones"}, 32'(bus.ONES_CNT), pop_exp());
        exp_sig = pop_exp();
        check({tag, "_sig"}, 32'(bus.SIG), exp_sig);
        repeat ($urandom_range(1, 4)) @(posedge CLK);
        #1;
        check({tag, "_sig_hold"}, 32'(bus.SIG), exp_sig);
        check({tag, "_done_hold"}, 32'(bus.DONE), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_stim"}, 32'(bus.STIM), 32'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_done"}, 32'(bus.DONE), 32'd0);
        check({tag, "_rise"}, 32'(bus.RISE_CNT), 32'd0);
        check({tag, "_fall"}, 32'(bus.FALL_CNT), 32'd0);
        check({tag, "_ones"}, 32'(bus.ONES_CNT), 32'd0);
        check({tag, "_sig"}, 32'(bus.SIG), 32'hFFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        logic        mode;
        logic [31:0] exp_sig;

        bus.START = 1'b0; bus.REPS = '0; bus.MODE = 1'b0;
        sat_bus.START = 1'b0; sat_bus.REPS = '0; sat_bus.MODE = 1'b0;
        cut_tt = 8'hF8;
        repeat (3) @(posedge CLK);
        #1;
        check_cleared("reset");
        RSTB = 1'b1;

        // AO21X1: Q = (IN1 & IN2) | IN3, indexed by STIM.
        run_seq(8'hF8, 1'b0, 1, "ao21_bin");
        check("ao21_bin_rise_k", 32'(bus.RISE_CNT), 32'd1);
        check("ao21_bin_fall_k", 32'(bus.FALL_CNT), 32'd0);
        check("ao21_bin_ones_k", 32'(bus.ONES_CNT), 32'd5);
        run_seq(8'hF8, 1'b1, 1, "ao21_gray");
        check("ao21_gray_rise_k", 32'(bus.RISE_CNT), 32'd2);
        check("ao21_gray_fall_k", 32'(bus.FALL_CNT), 32'd1);
        check("ao21_gray_ones_k", 32'(bus.ONES_CNT), 32'd5);
        run_seq(8'hF8, 1'b0, 2, "ao21_x2");
        check("ao21_x2_ones_k", 32'(bus.ONES_CNT), 32'd10);
        run_seq(8'hF8, 1'b0, 2, "ao21_restart");
        check("ao21_restart_ones_k", 32'(bus.ONES_CNT), 32'd10);
        run_seq(8'hF8, 1'b0, 0, "reps0");
        check("reps0_sig_k", 32'(bus.SIG), 32'hFFFF);

        // Narrow counters saturate; START pulses mid-run are ignored.
        mode = 1'($urandom);
        model_push(8'hFF, mode, 2, (1 << SAT_W) - 1);
        @(posedge CLK); #1;
        sat_bus.START = 1'b1; sat_bus.REPS = 8'd2; sat_bus.MODE = mode;
        edges = 0;
        forever begin
            @(posedge CLK); #1;
            edges++;
            if (sat_bus.DONE || edges >= 30) break;
            sat_bus.START = 1'($urandom_range(0, 1));
        end
        sat_bus.START = 1'b0;
        check("sat_latency", 32'(edges), 32'd18);
        check("sat_rise", 32'(sat_bus.RISE_CNT), pop_exp());
        check("sat_fall", 32'(sat_bus.FALL_CNT), pop_exp());
        check("sat_ones", 32'(sat_bus.ONES_CNT), pop_exp());
        exp_sig = pop_exp();
        check("sat_sig", 32'(sat_bus.SIG), exp_sig);

        // Reset lands on the edge that would take sample 4.
        cut_tt = 8'($urandom);
        @(posedge CLK); #1;
        bus.START = 1'b1; bus.REPS = 8'd2; bus.MODE = 1'($urandom);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("pre_reset_busy", 32'(bus.BUSY), 32'd1);
        RSTB = 1'b0;
        @(posedge CLK); #1;
        RSTB = 1'b1;
        check_cleared("mid_reset");
        run_seq(8'($urandom), 1'($urandom), $urandom_range(1, 3), "post_reset");

        for (int t = 0; t < 8; t++) begin
            run_seq(8'($urandom), 1'($urandom), $urandom_range(1, 4), $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
